// File: rtl/dsram_pkg.sv
// Shared definitions for the data-SRAM port arbiter: size encodings,
// requester IDs and the in-flight tag carried alongside each access.
package dsram_pkg;

    localparam logic [2:0] MODE_BYTE = 3'd0;
    localparam logic [2:0] MODE_HALF = 3'd1;
    localparam logic [2:0] MODE_WORD = 3'd2;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
        logic we;
    } tag_t;

endpackage

// File: rtl/dsram_rr_arb.sv
// Two-way round-robin arbiter with a bounded burst: the last winner may keep
// the grant under contention until it has taken MAX_BURST consecutive beats.
module dsram_rr_arb
    import dsram_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       last;
    logic [3:0] burst;
    logic       pick;

    // Pick the winner; a zero burst count means no live streak, so plain round-robin applies.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) begin
            if (burst != '0 && burst < 4'(MAX_BURST)) begin
                pick = last;
            end else begin
                pick = ~last;
            end
        end else begin
            pick = req[1];
        end
        gnt = '0;
        if (reset && req != 2'b00) begin
            gnt[pick] = 1'b1;
        end
    end

    // Track the last winner and the length of its contended streak.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last  <= PORT_AUX;
            burst <= '0;
        end else if (req != 2'b00) begin
            last <= pick;
            if (pick == last && req == 2'b11) begin
                burst <= (burst == 4'hf) ? burst : burst + 4'd1;
            end else begin
                burst <= 4'd1;
            end
        end else begin
            burst <= '0;
        end
    end

endmodule

// File: rtl/dsram_port_arbiter.sv
// Shares the data SRAM between the core MEM port (port 0) and an auxiliary
// master (port 1). Requests are muxed combinationally onto the SRAM and a
// tag pipeline routes each response back to its issuing port.
module dsram_port_arbiter
    import dsram_pkg::*;
#(
    parameter int unsigned SRAM_LAT  = 1,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_we,
    input  logic [2:0]  p0_mode,
    input  logic        p0_us,
    output logic        p0_resp_valid,
    output logic [31:0] p0_resp_rdata,
    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_we,
    input  logic [2:0]  p1_mode,
    input  logic        p1_us,
    output logic        p1_resp_valid,
    output logic [31:0] p1_resp_rdata,
    output logic        data_sram_en,
    output logic        data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    output logic [2:0]  data_sram_mode,
    output logic [2:0]  data_sram_write_mode,
    output logic        data_sram_us,
    input  logic [31:0] data_sram_rdata
);

    logic [1:0] gnt;
    tag_t       tag_in;
    tag_t       tag_out;
    tag_t       stage [SRAM_LAT];

    dsram_rr_arb #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({p1_req_valid, p0_req_valid}),
        .gnt   (gnt)
    );

    assign p0_req_ready = gnt[PORT_CORE];
    assign p1_req_ready = gnt[PORT_AUX];

    // Drive the SRAM from the granted port and build the tag for this beat.
    always_comb begin
        data_sram_en         = 1'b0;
        data_sram_we         = 1'b0;
        data_sram_addr       = '0;
        data_sram_wdata      = '0;
        data_sram_mode       = '0;
        data_sram_write_mode = '0;
        data_sram_us         = 1'b0;
        tag_in               = '0;
        if (gnt[PORT_CORE]) begin
            data_sram_en         = 1'b1;
            data_sram_we         = p0_we;
            data_sram_addr       = p0_addr;
            data_sram_wdata      = p0_wdata;
            data_sram_mode       = p0_mode;
            data_sram_write_mode = p0_mode;
            data_sram_us         = p0_us;
            tag_in               = '{valid: 1'b1, port: PORT_CORE, we: p0_we};
        end else if (gnt[PORT_AUX]) begin
            data_sram_en         = 1'b1;
            data_sram_we         = p1_we;
            data_sram_addr       = p1_addr;
            data_sram_wdata      = p1_wdata;
            data_sram_mode       = p1_mode;
            data_sram_write_mode = p1_mode;
            data_sram_us         = p1_us;
            tag_in               = '{valid: 1'b1, port: PORT_AUX, we: p1_we};
        end
    end

    // Shift tags in lockstep with the SRAM latency; reset drops everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SRAM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < SRAM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[SRAM_LAT-1];

    // Route the returning beat to its issuer; stores return zero data.
    always_comb begin
        p0_resp_valid = tag_out.valid && (tag_out.port == PORT_CORE);
        p1_resp_valid = tag_out.valid && (tag_out.port == PORT_AUX);
        p0_resp_rdata = (p0_resp_valid && !tag_out.we) ? data_sram_rdata : '0;
        p1_resp_rdata = (p1_resp_valid && !tag_out.we) ? data_sram_rdata : '0;
    end

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 3) share the same
// request and SRAM-data stimulus and are compared against a cycle model.
module tb_dsram_port_arbiter;
    import dsram_pkg::*;

    localparam int MAX_BURST = 4;
    localparam int LAT_A     = 1;
    localparam int LAT_B     = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic        p0_req_valid, p1_req_valid;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_we, p1_we, p0_us, p1_us;
    logic [2:0]  p0_mode, p1_mode;
    logic [31:0] sram_rdata;

    logic        a_p0_req_ready, a_p1_req_ready, a_p0_resp_valid, a_p1_resp_valid;
    logic [31:0] a_p0_resp_rdata, a_p1_resp_rdata;
    logic        a_en, a_we, a_us;
    logic [31:0] a_addr, a_wdata;
    logic [2:0]  a_mode, a_wmode;
    logic        b_p0_req_ready, b_p1_req_ready, b_p0_resp_valid, b_p1_resp_valid;
    logic [31:0] b_p0_resp_rdata, b_p1_resp_rdata;
    logic        b_en, b_we, b_us;
    logic [31:0] b_addr, b_wdata;
    logic [2:0]  b_mode, b_wmode;

    always #5 clk = ~clk;

    dsram_port_arbiter #(.SRAM_LAT(LAT_A), .MAX_BURST(MAX_BURST)) u_dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(a_p0_req_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_mode(p0_mode), .p0_us(p0_us),
        .p0_resp_valid(a_p0_resp_valid), .p0_resp_rdata(a_p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(a_p1_req_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_mode(p1_mode), .p1_us(p1_us),
        .p1_resp_valid(a_p1_resp_valid), .p1_resp_rdata(a_p1_resp_rdata),
        .data_sram_en(a_en), .data_sram_we(a_we), .data_sram_addr(a_addr),
        .data_sram_wdata(a_wdata), .data_sram_mode(a_mode), .data_sram_write_mode(a_wmode),
        .data_sram_us(a_us), .data_sram_rdata(sram_rdata)
    );

    dsram_port_arbiter #(.SRAM_LAT(LAT_B), .MAX_BURST(MAX_BURST)) u_dut_lat3 (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(b_p0_req_ready), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_we(p0_we), .p0_mode(p0_mode), .p0_us(p0_us),
        .p0_resp_valid(b_p0_resp_valid), .p0_resp_rdata(b_p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(b_p1_req_ready), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_we(p1_we), .p1_mode(p1_mode), .p1_us(p1_us),
        .p1_resp_valid(b_p1_resp_valid), .p1_resp_rdata(b_p1_resp_rdata),
        .data_sram_en(b_en), .data_sram_we(b_we), .data_sram_addr(b_addr),
        .data_sram_wdata(b_wdata), .data_sram_mode(b_mode), .data_sram_write_mode(b_wmode),
        .data_sram_us(b_us), .data_sram_rdata(sram_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who won last, how long its contended streak is, and an
    // issue history indexed by cycle from which responses are looked up.
    int   m_last, m_streak, cyc;
    bit   hv [8];
    bit   hp [8];
    bit   hwe [8];
    int   e_gnt;
    bit   e_both;
    logic e_en, e_we, e_us;
    logic [31:0] e_addr, e_wdata;
    logic [2:0]  e_mode;
    logic e_rv0_a, e_rv1_a, e_rv0_b, e_rv1_b;
    logic [31:0] e_rd0_a, e_rd1_a, e_rd0_b, e_rd1_b;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) hv[i] = 1'b0;
        m_last   = 1;
        m_streak = 0;
    endtask

    task automatic resp_model(input int lat, output logic v0, output logic v1,
                              output logic [31:0] r0, output logic [31:0] r1);
        int idx;
        idx = (cyc - lat) % 8;
        v0 = reset && hv[idx] && !hp[idx];
        v1 = reset && hv[idx] && hp[idx];
        r0 = (v0 && !hwe[idx]) ? sram_rdata : 32'h0;
        r1 = (v1 && !hwe[idx]) ? sram_rdata : 32'h0;
    endtask

    task automatic model_eval();
        int w;
        w = -1;
        e_both = p0_req_valid && p1_req_valid;
        if (reset) begin
            if (e_both) w = (m_streak > 0 && m_streak < MAX_BURST) ? m_last : 1 - m_last;
            else if (p0_req_valid) w = 0;
            else if (p1_req_valid) w = 1;
        end
        e_gnt   = w;
        e_en    = (w >= 0);
        e_we    = (w == 0) ? p0_we    : (w == 1) ? p1_we    : 1'b0;
        e_us    = (w == 0) ? p0_us    : (w == 1) ? p1_us    : 1'b0;
        e_addr  = (w == 0) ? p0_addr  : (w == 1) ? p1_addr  : 32'h0;
        e_wdata = (w == 0) ? p0_wdata : (w == 1) ? p1_wdata : 32'h0;
        e_mode  = (w == 0) ? p0_mode  : (w == 1) ? p1_mode  : 3'h0;
        resp_model(LAT_A, e_rv0_a, e_rv1_a, e_rd0_a, e_rd1_a);
        resp_model(LAT_B, e_rv0_b, e_rv1_b, e_rd0_b, e_rd1_b);
    endtask

    task automatic model_commit();
        int idx;
        idx = cyc % 8;
        hv[idx]  = e_en;
        hp[idx]  = (e_gnt == 1);
        hwe[idx] = e_we;
        if (e_en) begin
            if (e_gnt == m_last && e_both) m_streak++;
            else m_streak = 1;
            m_last = e_gnt;
        end else begin
            m_streak = 0;
        end
        cyc++;
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b0;
        model_clear();
        repeat (cycles) tick();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        p0_we = 1'b0; p1_we = 1'b0; p0_us = 1'b0; p1_us = 1'b0;
        p0_mode = MODE_WORD; p1_mode = MODE_WORD;
        p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        p0_req_valid = 1'b1; p1_req_valid = 1'b1;
        p0_addr = 32'h44; p1_addr = 32'h88; p0_wdata = 32'h1; p1_wdata = 32'h2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_p0_req_ready, a_p1_req_ready, a_en, a_we, a_p0_resp_valid, a_p1_resp_valid} !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_ctrl got=%b exp=000000",
                         {a_p0_req_ready, a_p1_req_ready, a_en, a_we, a_p0_resp_valid, a_p1_resp_valid});
            end
            n_checks++;
            if ({a_addr, a_wdata} !== 64'h0) begin
                n_errors++;
                $display("FAIL reset_data got addr=%h wdata=%h exp 0", a_addr, a_wdata);
            end
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        p0_req_valid = 1'b1; p0_addr = 32'h100; p0_mode = MODE_WORD; p0_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_p0_req_ready, a_en, a_we} !== 3'b110 || a_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL single_issue got rdy/en/we=%b addr=%h exp 110 00000100", {a_p0_req_ready, a_en, a_we}, a_addr);
        end
        tick();
        p0_req_valid = 1'b0;
        sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        n_checks++;
        if (a_p0_resp_valid !== 1'b1 || a_p0_resp_rdata !== 32'hDEADBEEF || a_p1_resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_resp got v0=%b d=%h v1=%b exp 1 deadbeef 0", a_p0_resp_valid, a_p0_resp_rdata, a_p1_resp_valid);
        end
        tick();
    endtask

    task automatic test_tie_burst();
        int seq [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
        apply_reset(2);
        p0_req_valid = 1'b1; p1_req_valid = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_p0_req_ready !== (seq[i] == 0) || a_p1_req_ready !== (seq[i] == 1)) begin
                n_errors++;
                $display("FAIL tie_seq beat=%0d got r0=%b r1=%b exp port %0d", i, a_p0_req_ready, a_p1_req_ready, seq[i]);
            end
            tick();
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_store_load();
        p1_req_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h55; p1_mode = MODE_BYTE;
        sram_rdata = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if ({a_en, a_we, a_mode, a_wmode} !== {1'b1, 1'b1, MODE_BYTE, MODE_BYTE} || a_addr !== 32'h20 || a_wdata !== 32'h55) begin
            n_errors++;
            $display("FAIL store_issue got en/we=%b%b mode=%0d wmode=%0d addr=%h wdata=%h", a_en, a_we, a_mode, a_wmode, a_addr, a_wdata);
        end
        tick();
        p1_req_valid = 1'b0; p1_we = 1'b0;
        p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h20; p0_mode = MODE_WORD;
        sram_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        n_checks++;
        if ({a_en, a_we} !== 2'b10 || a_addr !== 32'h20) begin
            n_errors++;
            $display("FAIL load_issue got en/we=%b%b addr=%h exp 10 00000020", a_en, a_we, a_addr);
        end
        n_checks++;
        if ({a_p1_resp_valid, a_p0_resp_valid} !== 2'b10 || a_p1_resp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL store_ack got v1/v0=%b%b d=%h exp 10 00000000", a_p1_resp_valid, a_p0_resp_valid, a_p1_resp_rdata);
        end
        tick();
        p0_req_valid = 1'b0;
        sram_rdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (a_p0_resp_valid !== 1'b1 || a_p0_resp_rdata !== 32'hCAFEF00D || a_p1_resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL load_after_store got v0=%b d=%h v1=%b", a_p0_resp_valid, a_p0_resp_rdata, a_p1_resp_valid);
        end
        tick();
    endtask

    task automatic test_latency();
        idle_inputs();
        repeat (4) tick();
        for (int k = 0; k < 6; k++) begin
            p0_req_valid = (k < 3);
            p0_addr = 32'h200 + 32'(4 * k);
            sram_rdata = 32'h10000000 + 32'(k);
            @(negedge clk);
            n_checks++;
            if (k >= 3) begin
                if (b_p0_resp_valid !== 1'b1 || b_p0_resp_rdata !== 32'h10000000 + 32'(k) || b_p1_resp_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL lat3_resp k=%0d got v0=%b d=%h v1=%b", k, b_p0_resp_valid, b_p0_resp_rdata, b_p1_resp_valid);
                end
            end else if (b_p0_resp_valid !== 1'b0 || b_p1_resp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL lat3_early k=%0d got v0=%b v1=%b exp 0 0", k, b_p0_resp_valid, b_p1_resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        p0_req_valid = 1'b1; p0_we = 1'b0;
        tick();
        p0_req_valid = 1'b0; p1_req_valid = 1'b1; p1_we = 1'b0;
        tick();
        p0_req_valid = 1'b1;
        reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if ({a_p0_req_ready, a_p1_req_ready, a_en, a_p0_resp_valid, a_p1_resp_valid,
             b_p0_resp_valid, b_p1_resp_valid} !== 7'b0) begin
            n_errors++;
            $display("FAIL midflight_assert got %b exp 0000000", {a_p0_req_ready, a_p1_req_ready, a_en,
                     a_p0_resp_valid, a_p1_resp_valid, b_p0_resp_valid, b_p1_resp_valid});
        end
        tick();
        tick();
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_p0_req_ready, a_p1_req_ready, a_p0_resp_valid, a_p1_resp_valid,
                 b_p0_resp_valid, b_p1_resp_valid} !== 6'b0) begin
                n_errors++;
                $display("FAIL midflight_drop cyc=%0d got %b exp 000000", i, {a_p0_req_ready, a_p1_req_ready,
                         a_p0_resp_valid, a_p1_resp_valid, b_p0_resp_valid, b_p1_resp_valid});
            end
            tick();
        end
        p0_req_valid = 1'b1; p1_req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_p0_req_ready, a_p1_req_ready} !== 2'b10) begin
            n_errors++;
            $display("FAIL midflight_first_tie got r0r1=%b exp 10", {a_p0_req_ready, a_p1_req_ready});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            p0_addr = $urandom; p1_addr = $urandom; p0_wdata = $urandom; p1_wdata = $urandom;
            p0_we = 1'b1; p1_we = 1'b1; p0_us = 1'b1; p1_us = 1'b1; p0_mode = MODE_HALF; p1_mode = MODE_HALF;
            @(negedge clk);
            n_checks++;
            if ({a_en, a_we, a_mode, a_wmode, a_us} !== 9'b0 || a_addr !== 32'h0 || a_wdata !== 32'h0) begin
                n_errors++;
                $display("FAIL idle_sram cyc=%0d got en=%b we=%b mode=%0d wmode=%0d us=%b addr=%h wdata=%h",
                         i, a_en, a_we, a_mode, a_wmode, a_us, a_addr, a_wdata);
            end
            tick();
        end
        // Port 0 won the last beat before the idle gap, so the tie goes to port 1.
        p0_req_valid = 1'b1; p1_req_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_p0_req_ready, a_p1_req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL idle_next_tie got r0r1=%b exp 01", {a_p0_req_ready, a_p1_req_ready});
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            p0_req_valid = ($urandom_range(0, 99) < 70);
            p1_req_valid = ($urandom_range(0, 99) < 60);
            p0_addr = $urandom; p1_addr = $urandom; p0_wdata = $urandom; p1_wdata = $urandom;
            p0_we = 1'($urandom); p1_we = 1'($urandom); p0_us = 1'($urandom); p1_us = 1'($urandom);
            p0_mode = 3'($urandom_range(0, 2)); p1_mode = 3'($urandom_range(0, 2));
            sram_rdata = $urandom;
            model_eval();
            @(negedge clk);
            n_checks++;
            if ({a_p0_req_ready, a_p1_req_ready, b_p0_req_ready, b_p1_req_ready} !==
                {e_gnt == 0, e_gnt == 1, e_gnt == 0, e_gnt == 1}) begin
                n_errors++;
                $display("FAIL rnd_ready i=%0d got a=%b%b b=%b%b exp port %0d", i, a_p0_req_ready, a_p1_req_ready,
                         b_p0_req_ready, b_p1_req_ready, e_gnt);
            end
            n_checks++;
            if ({a_en, a_we, a_mode, a_wmode, a_us, a_addr, a_wdata} !==
                {e_en, e_we, e_mode, e_mode, e_us, e_addr, e_wdata}) begin
                n_errors++;
                $display("FAIL rnd_sram i=%0d got en=%b we=%b m=%0d wm=%0d us=%b a=%h d=%h exp en=%b we=%b m=%0d us=%b a=%h d=%h",
                         i, a_en, a_we, a_mode, a_wmode, a_us, a_addr, a_wdata, e_en, e_we, e_mode, e_us, e_addr, e_wdata);
            end
            n_checks++;
            if ({a_p0_resp_valid, a_p1_resp_valid, a_p0_resp_rdata, a_p1_resp_rdata} !==
                {e_rv0_a, e_rv1_a, e_rd0_a, e_rd1_a}) begin
                n_errors++;
                $display("FAIL rnd_resp_lat1 i=%0d got v=%b%b d0=%h d1=%h exp v=%b%b d0=%h d1=%h", i, a_p0_resp_valid,
                         a_p1_resp_valid, a_p0_resp_rdata, a_p1_resp_rdata, e_rv0_a, e_rv1_a, e_rd0_a, e_rd1_a);
            end
            n_checks++;
            if ({b_p0_resp_valid, b_p1_resp_valid, b_p0_resp_rdata, b_p1_resp_rdata} !==
                {e_rv0_b, e_rv1_b, e_rd0_b, e_rd1_b}) begin
                n_errors++;
                $display("FAIL rnd_resp_lat3 i=%0d got v=%b%b d0=%h d1=%h exp v=%b%b d0=%h d1=%h", i, b_p0_resp_valid,
                         b_p1_resp_valid, b_p0_resp_rdata, b_p1_resp_rdata, e_rv0_b, e_rv1_b, e_rd0_b, e_rd1_b);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        sram_rdata = '0;
        cyc = 8;
        model_clear();
        for (int i = 0; i < 8; i++) begin
            hp[i] = 1'b0;
            hwe[i] = 1'b0;
        end
        #1;
        test_reset();
        test_single_read();
        test_tie_burst();
        test_store_load();
        test_latency();
        test_reset_midflight();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dsram_port_arbiter.md
# dsram_port_arbiter

Two-requester arbiter that shares the single data SRAM between the core's MEM-stage load/store port (port 0) and an auxiliary master such as DMA or debug (port 1). It accepts one access per cycle over valid/ready handshakes and drives the SRAM request lines combinationally from the granted port. It tracks in-flight grants so each response returns to the port that issued it. It sits between the EX/MEM pipeline register and the data SRAM and replaces the direct `data_sram_*` connection.

## Interface
Parameters:
- `SRAM_LAT`, 1: SRAM read latency in cycles, from `data_sram_en` to valid `data_sram_rdata`. Legal range is 1–4.
- `MAX_BURST`, 4: maximum consecutive grants to one port while the other port is requesting. Legal range is 1–15.

Ports (`pN_*` is replicated for N = 0, 1):
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `pN_req_valid` in 1: request present.
- `pN_req_ready` out 1: request accepted this cycle.
- `pN_addr` in 32: byte address.
- `pN_wdata` in 32: write data.
- `pN_we` in 1: 1 = store, 0 = load.
- `pN_mode` in 3: access size (byte/half/word encoding).
- `pN_us` in 1: load is unsigned.
- `pN_resp_valid` out 1: response for this port (load data or store ack).
- `pN_resp_rdata` out 32: load data. It is 0 for stores.
- `data_sram_en` out 1: SRAM access enable.
- `data_sram_we` out 1: SRAM write enable.
- `data_sram_addr` out 32.
- `data_sram_wdata` out 32.
- `data_sram_mode` out 3: read size.
- `data_sram_write_mode` out 3: write size.
- `data_sram_us` out 1.
- `data_sram_rdata` in 32.

## Operation
- **Grant rule:** exactly one grant per cycle, and only when at least one `pN_req_valid` is high.
  - If only one port requests, it wins.
  - If both request, the winner is the port not granted last (round-robin pointer `last`).
  - Burst override: if the burst counter of the last-granted port is below `MAX_BURST`, that port keeps the grant.
- **Burst counter** (4 bits):
  - Increments on each consecutive grant to the same port while the other port is also requesting.
  - Resets to 1 when the granted port changes.
  - Resets to 0 on any cycle with no grant.
- **Ready:** `pN_req_ready` = grant to N. Ready never depends on response state, because responses cannot be back-pressured.
- **Acceptance:** a request is accepted when `valid && ready`.
- **SRAM drive:** while granted, the SRAM outputs mirror the granted port's fields.
  - `data_sram_en` = 1.
  - `data_sram_we` = `pN_we`.
  - `data_sram_mode` and `data_sram_write_mode` = `pN_mode`.
  - With no grant, all SRAM outputs are 0.
- **Tag pipeline:** `SRAM_LAT` stages of {valid, port, we}, shifted every cycle. Stage 0 is loaded with the grant of the current cycle.
- **Response:** at the final stage, the tagged port's `resp_valid` = 1.
  - `resp_rdata` = `data_sram_rdata` if it was a load, else 0.
  - The other port's `resp_valid` = 0.
- **Ordering:** responses are strictly in issue order, so at most one `resp_valid` is high per cycle.
- **Reset:** asynchronous assert clears `last` (to port 1, so port 0 wins the first tie), the burst counter, and all tag stages. Every output is 0 during reset, including both ready signals.
- **Reset mid-flight:** in-flight accesses are dropped and no responses are produced for them. A store issued in the same cycle as reset assertion is not guaranteed to be written.

## Timing
- Request to SRAM: 0 cycles, combinational from `pN_req_valid` and state.
- Accept to `pN_resp_valid`: exactly `SRAM_LAT` cycles.
- Throughput: 1 access per cycle aggregate. With continuous contention, each port gets at least 1 of every `MAX_BURST`+1 cycles.
- Back-to-back accepts from one port are legal. Responses appear in consecutive cycles after `SRAM_LAT`.
- Simultaneous response and new request on the same port: independent, and both occur.
- Port switch: no bubble between the last beat of one port and the first beat of the other.
- Reset deassertion: the first grant is possible on the first rising edge after `reset` goes high.

## Structure
- **Shared package `dsram_pkg`:**
  - Size encodings `MODE_BYTE`=3'd0, `MODE_HALF`=3'd1, `MODE_WORD`=3'd2.
  - Port IDs `PORT_CORE`=1'b0, `PORT_AUX`=1'b1.
  - The tag struct {valid, port, we}.
- **Sub-module `dsram_rr_arb`:** holds the round-robin pointer and burst counter. Inputs are the two valid signals; outputs are `gnt[1:0]`.
- **Top level:** the request mux, the tag shift register and the response demux stay in the top module.

## Test plan
- **Single port read:** port 0 load at `addr`=0x100 (word), SRAM returns 0xDEADBEEF after 1 cycle → `p0_resp_valid` at accept+1 with 0xDEADBEEF; `p1_resp_valid` stays 0.
- **Tie on first request after reset:** both ports request → port 0 granted first. With continuous requests and `MAX_BURST`=4 the grant sequence is 0,0,0,0,1,1,1,1,0…; no port waits more than 4 cycles.
- **Interleaved store then load:** port 1 store 0x55 (byte) to 0x20, then port 0 load of 0x20 next cycle → SRAM sees `we`=1 then `we`=0 in consecutive cycles. `p1_resp_valid` has rdata 0; `p0_resp_valid` follows one cycle later.
- **Latency parameter:** `SRAM_LAT`=3, port 0 issues 3 back-to-back loads → three consecutive responses at accept+3, in order, routed to port 0.
- **Reset mid-flight:** `reset` pulled low with 2 accesses in flight → no `resp_valid` afterwards. After release, both ready signals are 0 until a valid arrives, and the first tie goes to port 0.
- **Idle:** no valids for 10 cycles → `data_sram_en`=0 and all SRAM outputs 0; the burst counter is 0 on the next contention.
